// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC chains: Q2.13 angle format, atan table,
// canonical NaN and the vectoring FSM state encoding.
package cordic_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int ITER_DEF  = 13;

   localparam int Q_INT  = 2;
   localparam int Q_FRAC = 13;
   localparam int Z_W    = 1 + Q_INT + Q_FRAC;

   localparam logic signed [Z_W-1:0] PI_Q13      = 16'sd25736;
   localparam logic signed [Z_W-1:0] HALF_PI_Q13 = 16'sd12868;

   localparam logic [31:0] NAN_CANON = 32'h7FC0_0000;

   // single-precision bias with the Q2.13 binary point folded in (127 - 13)
   localparam logic [7:0] F32_BIAS_Q = 8'd114;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ALIGN   = 3'd1,
      ST_PREROT  = 3'd2,
      ST_ITERATE = 3'd3,
      ST_PACK    = 3'd4
   } state_t;

   function automatic logic signed [Z_W-1:0] atan_tab(input logic [3:0] i);
      case (i)
         4'd0:    return 16'sd6434;
         4'd1:    return 16'sd3798;
         4'd2:    return 16'sd2007;
         4'd3:    return 16'sd1019;
         4'd4:    return 16'sd511;
         4'd5:    return 16'sd256;
         4'd6:    return 16'sd128;
         4'd7:    return 16'sd64;
         4'd8:    return 16'sd32;
         4'd9:    return 16'sd16;
         4'd10:   return 16'sd8;
         4'd11:   return 16'sd4;
         4'd12:   return 16'sd2;
         default: return 16'sd0;
      endcase
   endfunction

endpackage

// File: rtl/q13_to_ieee754.sv
// Converts a signed Q2.13 angle to an IEEE-754 single (truncating, zero-exact).
// Purely combinational so any Q2.13 producer can reuse it.
module q13_to_ieee754
   import cordic_pkg::*;
(
   input  logic signed [Z_W-1:0] i_z,
   output logic [31:0]           o_ieee754
);

   logic [Z_W-1:0] w_mag;
   logic [3:0]     w_msb;
   logic [4:0]     w_shift;
   logic [22:0]    w_mant;
   logic [7:0]     w_exp;

   always_comb begin
      w_mag = i_z[Z_W-1] ? $unsigned(-i_z) : $unsigned(i_z);
      w_msb = '0;
      for (int k = 0; k < Z_W; k++) begin
         if (w_mag[k]) w_msb = 4'(k);
      end
      // the hidden bit falls off the top of the 23-bit field
      w_shift   = 5'd23 - {1'b0, w_msb};
      w_mant    = {7'd0, w_mag} << w_shift;
      w_exp     = F32_BIAS_Q + {4'd0, w_msb};
      o_ieee754 = (w_mag == '0) ? 32'd0 : {i_z[Z_W-1], w_exp, w_mant};
   end

endmodule

// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: atan2(y, x) from two IEEE half operands to an IEEE
// single angle, one micro-rotation per clock.
//
// state   | meaning
// IDLE    | ready high, waits for valid_in; operands captured on accept
// ALIGN   | unpack halves, align mantissas to the larger exponent, apply signs
// PREROT  | fold the left half-plane onto the right, seed z with +/-pi or 0
// ITERATE | ITER micro-rotations driving y toward zero
// PACK    | convert z, register outputs, pulse done on the way back to IDLE
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ITER  = ITER_DEF
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid_in,
   input  logic [15:0] i_x_ieee754,
   input  logic [15:0] i_y_ieee754,
   output logic [31:0] o_angle_ieee754,
   output logic [1:0]  o_quadrant,
   output logic        o_nan_out,
   output logic        o_ready,
   output logic        o_done
);

   localparam int XW    = WIDTH + 1;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

   state_t r_state, w_next;

   logic [15:0]             r_x_h, r_y_h;
   logic signed [XW-1:0]    r_x, r_y;
   logic signed [Z_W-1:0]   r_z;
   logic [CNT_W-1:0]        r_iter;
   logic                    r_inv, r_zero;
   logic [31:0]             r_angle;
   logic [1:0]              r_quad;
   logic                    r_nan, r_done;

   logic                    w_accept, w_last;
   logic [4:0]              w_xe, w_ye, w_ediff;
   logic [10:0]             w_xm, w_ym;
   logic                    w_x_ge, w_y_ge, w_inv, w_zero;
   logic [WIDTH-1:0]        w_x_pl, w_y_pl, w_x_mag, w_y_mag;
   logic signed [XW-1:0]    w_x_al, w_y_al, w_x_sh, w_y_sh;
   logic signed [Z_W-1:0]   w_atan;
   logic [31:0]             w_ieee;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (i_valid_in) w_next = ST_ALIGN;
         ST_ALIGN:   w_next = ST_PREROT;
         ST_PREROT:  w_next = ST_ITERATE;
         ST_ITERATE: if (w_last) w_next = ST_PACK;
         ST_PACK:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ready  = (r_state == ST_IDLE);
      w_accept = o_ready & i_valid_in;
   end

   // Subnormals flush to zero; exponent 31 (inf/NaN) poisons the result.
   always_comb begin
      w_xe    = r_x_h[14:10];
      w_ye    = r_y_h[14:10];
      w_xm    = (w_xe == 5'd0) ? 11'd0 : {1'b1, r_x_h[9:0]};
      w_ym    = (w_ye == 5'd0) ? 11'd0 : {1'b1, r_y_h[9:0]};
      w_inv   = (w_xe == 5'h1F) | (w_ye == 5'h1F);
      w_x_ge  = (w_xe >= w_ye);
      w_y_ge  = (w_ye >= w_xe);
      w_ediff = w_x_ge ? (w_xe - w_ye) : (w_ye - w_xe);
      w_x_pl  = {{(WIDTH-13){1'b0}}, w_xm, 2'b00};
      w_y_pl  = {{(WIDTH-13){1'b0}}, w_ym, 2'b00};
      w_x_mag = w_x_ge ? w_x_pl : ((int'(w_ediff) >= WIDTH) ? '0 : (w_x_pl >> w_ediff));
      w_y_mag = w_y_ge ? w_y_pl : ((int'(w_ediff) >= WIDTH) ? '0 : (w_y_pl >> w_ediff));
      w_x_al  = r_x_h[15] ? -$signed({1'b0, w_x_mag}) : $signed({1'b0, w_x_mag});
      w_y_al  = r_y_h[15] ? -$signed({1'b0, w_y_mag}) : $signed({1'b0, w_y_mag});
      // y exactly zero on the non-negative x axis (or at the origin) is an exact 0
      w_zero  = (w_y_mag == '0) && ((w_x_mag == '0) || !r_x_h[15]);
   end

   always_comb begin
      w_x_sh = r_x >>> r_iter;
      w_y_sh = r_y >>> r_iter;
      w_atan = atan_tab(r_iter);
      w_last = (r_iter == LAST_ITER);
   end

   q13_to_ieee754 u_pack (
      .i_z       (r_z),
      .o_ieee754 (w_ieee)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x_h   <= '0;
         r_y_h   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_iter  <= '0;
         r_inv   <= 1'b0;
         r_zero  <= 1'b0;
         r_angle <= '0;
         r_quad  <= '0;
         r_nan   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_x_h <= i_x_ieee754;
                  r_y_h <= i_y_ieee754;
               end
            end
            ST_ALIGN: begin
               r_x    <= w_x_al;
               r_y    <= w_y_al;
               r_inv  <= w_inv;
               r_zero <= w_zero;
            end
            ST_PREROT: begin
               r_iter <= '0;
               if (r_x[XW-1]) begin
                  r_x <= -r_x;
                  r_y <= -r_y;
                  r_z <= r_y_h[15] ? -PI_Q13 : PI_Q13;
               end else begin
                  r_z <= '0;
               end
            end
            ST_ITERATE: begin
               if (!r_y[XW-1]) begin
                  r_x <= r_x + w_y_sh;
                  r_y <= r_y - w_x_sh;
                  r_z <= r_z + w_atan;
               end else begin
                  r_x <= r_x - w_y_sh;
                  r_y <= r_y + w_x_sh;
                  r_z <= r_z - w_atan;
               end
               r_iter <= w_last ? '0 : r_iter + 1'b1;
            end
            ST_PACK: begin
               r_angle <= r_inv ? NAN_CANON : (r_zero ? 32'd0 : w_ieee);
               r_quad  <= {r_x_h[15], r_y_h[15]};
               r_nan   <= r_inv;
               r_done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_angle_ieee754 = r_angle;
   assign o_quadrant      = r_quad;
   assign o_nan_out       = r_nan;
   assign o_done          = r_done;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: directed vectors plus back-to-back
// random operands against a real-valued atan2 model.
module tb_cordic_vectoring;

   localparam real PI  = 3.14159265358979324;
   localparam real TOL = 0.0009765625;
   localparam int  LAT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [15:0] x = '0, y = '0;
   logic [31:0] o_angle;
   logic [1:0]  o_quadrant;
   logic        o_nan, o_ready, o_done;

   typedef struct {
      string       name;
      logic        exact;
      logic [31:0] bits;
      real         ang;
      logic        nan;
      logic [1:0]  quad;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, errors = 0, done_count = 0, cyc = 0;

   cordic_vectoring dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_valid_in      (valid),
      .i_x_ieee754     (x),
      .i_y_ieee754     (y),
      .o_angle_ieee754 (o_angle),
      .o_quadrant      (o_quadrant),
      .o_nan_out       (o_nan),
      .o_ready         (o_ready),
      .o_done          (o_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic real h2r(input logic [15:0] h);
      int  e;
      real m;
      e = int'(h[14:10]);
      if (e == 0) return 0.0;
      m = (1.0 + real'(h[9:0]) / 1024.0) * (2.0 ** (e - 15));
      return h[15] ? -m : m;
   endfunction

   function automatic real f2r(input logic [31:0] b);
      int  e;
      real m;
      e = int'(b[30:23]);
      if (e == 0) return 0.0;
      m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      return b[31] ? -m : m;
   endfunction

   task automatic check_bits(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
      end
   endtask

   task automatic check_ang(input string nm, input logic [31:0] act, input real expv);
      real d;
      checks++;
      d = f2r(act) - expv;
      if (d > PI) d = d - 2.0 * PI;
      else if (d < -PI) d = d + 2.0 * PI;
      if (d < 0.0) d = -d;
      if (act[30:23] == 8'hFF || d > TOL) begin
         errors++;
         $display("FAIL %s: got 0x%08h (%f rad), expected %f rad within %f", nm, act, f2r(act), expv, TOL);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && o_done) begin
         done_count++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with angle 0x%08h, expected no done", o_angle);
         end else begin
            e = sb.pop_front();
            check_bits({e.name, ".latency"}, 32'(cyc - e.acc), 32'(LAT));
            check_bits({e.name, ".quadrant"}, 32'(o_quadrant), 32'(e.quad));
            check_bits({e.name, ".nan_out"}, 32'(o_nan), 32'(e.nan));
            check_bits({e.name, ".ready"}, 32'(o_ready), 32'd1);
            if (e.exact) check_bits({e.name, ".angle"}, o_angle, e.bits);
            else         check_ang({e.name, ".angle"}, o_angle, e.ang);
         end
      end
   end

   // Called on a negedge; returns on the negedge after the accepting edge.
   task automatic issue(input string nm, input logic [15:0] xi, input logic [15:0] yi,
                        input logic exact, input logic [31:0] bits, input real ang,
                        input logic nan, input logic b2b);
      exp_t e;
      int   g;
      valid = 1'b1;
      x = xi;
      y = yi;
      g = 0;
      while (!o_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!o_ready) begin
         checks++;
         errors++;
         $display("FAIL %s.accept: ready low for %0d cycles, expected high", nm, g);
      end else begin
         if (b2b) check_bits({nm, ".b2b_done"}, 32'(o_done), 32'd1);
         e.name  = nm;
         e.exact = exact;
         e.bits  = bits;
         e.ang   = ang;
         e.nan   = nan;
         e.quad  = {xi[15], yi[15]};
         e.acc   = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      int g;
      g = 0;
      while (sb.size() != 0 && g < limit) begin
         @(negedge clk);
         g++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d results outstanding after %0d cycles, expected 0", sb.size(), limit);
         sb.delete();
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      check_bits({nm, ".angle"}, o_angle, 32'd0);
      check_bits({nm, ".quadrant"}, 32'(o_quadrant), 32'd0);
      check_bits({nm, ".nan_out"}, 32'(o_nan), 32'd0);
      check_bits({nm, ".done"}, 32'(o_done), 32'd0);
      check_bits({nm, ".ready"}, 32'(o_ready), 32'd1);
   endtask

   function automatic logic [15:0] rand_half();
      logic       s;
      logic [4:0] e;
      logic [9:0] f;
      s = 1'($urandom_range(0, 1));
      e = 5'($urandom_range(12, 18));
      f = 10'($urandom_range(0, 1023));
      return {s, e, f};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int          dc;
      logic [15:0] xr, yr;

      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      issue("pi4",        16'h3C00, 16'h3C00, 1'b0, 32'd0,  PI / 4.0, 1'b0, 1'b0); wait_drain(40);
      issue("pos_pi",     16'hBC00, 16'h0000, 1'b0, 32'd0,  PI,       1'b0, 1'b0); wait_drain(40);
      issue("neg_pi",     16'hBC00, 16'h8000, 1'b0, 32'd0, -PI,       1'b0, 1'b0); wait_drain(40);
      issue("neg_hpi",    16'h0000, 16'hC000, 1'b0, 32'd0, -PI / 2.0, 1'b0, 1'b0); wait_drain(40);
      issue("max_sub",    16'h7BFF, 16'h0001, 1'b1, 32'd0,  0.0,      1'b0, 1'b0); wait_drain(40);
      issue("zero_zero",  16'h0000, 16'h0000, 1'b1, 32'd0,  0.0,      1'b0, 1'b0); wait_drain(40);
      issue("nzero_nzero",16'h8000, 16'h8000, 1'b1, 32'd0,  0.0,      1'b0, 1'b0); wait_drain(40);

      // extra valid pulses 3 and 8 cycles after accept must be dropped
      dc = done_count;
      issue("pulse_first", 16'h3C00, 16'hBC00, 1'b0, 32'd0, -PI / 4.0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      valid = 1'b1; x = 16'h4000; y = 16'h0000;
      @(negedge clk);
      valid = 1'b0;
      repeat (4) @(negedge clk);
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      wait_drain(40);
      repeat (20) @(negedge clk);
      check_bits("pulse_ignored.done_count", 32'(done_count - dc), 32'd1);

      issue("x_nan", 16'h7E00, 16'h3C00, 1'b1, 32'h7FC0_0000, 0.0, 1'b1, 1'b0); wait_drain(40);
      issue("y_inf", 16'hBC00, 16'h7C00, 1'b1, 32'h7FC0_0000, 0.0, 1'b1, 1'b0); wait_drain(40);

      // async reset at ITERATE step 5 aborts with no done
      dc = done_count;
      issue("aborted", 16'h4000, 16'h3C00, 1'b0, 32'd0, 0.0, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midop_rst");
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check_bits("midop_rst.no_done", 32'(done_count - dc), 32'd0);
      check_reset_outputs("after_rst");
      issue("after_rst", 16'h3C00, 16'h3C00, 1'b0, 32'd0, PI / 4.0, 1'b0, 1'b0); wait_drain(40);

      // valid held high: each request is taken in the previous done cycle
      for (int k = 0; k < 8; k++) begin
         xr = rand_half();
         yr = rand_half();
         issue($sformatf("rand%0d", k), xr, yr, 1'b0, 32'd0, $atan2(h2r(yr), h2r(xr)), 1'b0, k > 0);
      end
      wait_drain(40);
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
